// File: rtl/operand_capture_pkg.sv
// Shared definitions for the operand capture front end.
// Holds the FSM state encoding and the short debounce period used in simulation.
package operand_capture_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/operand_capture_sync2.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module operand_capture_sync2 #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/operand_capture.sv
// Synchronises the switches and a push button, debounces the button and latches the
// switches into operand A once per confirmed press.
module operand_capture
   import operand_capture_pkg::*;
#(
   parameter int DATA_W          = 16,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19,
   parameter int LCNT_W          = 8
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              KEY_N,
   input  logic [DATA_W-1:0] SW,
   output logic [DATA_W-1:0] A,
   output logic              A_VALID,
   output logic              KEY_HELD,
   output logic [LCNT_W-1:0] LOAD_CNT
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic              key_s;
   logic [DATA_W-1:0] sw_s;
   state_t            state;
   logic [CNT_W-1:0]  cnt;

   // Key idles released (high) so reset never looks like a press.
   operand_capture_sync2 #(.W(1), .RST_VAL(1'b1)) u_key_sync (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .d     (KEY_N),
      .q     (key_s)
   );

   operand_capture_sync2 #(.W(DATA_W), .RST_VAL('0)) u_sw_sync (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .d     (SW),
      .q     (sw_s)
   );

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         cnt      <= '0;
         A        <= '0;
         A_VALID  <= 1'b0;
         KEY_HELD <= 1'b0;
         LOAD_CNT <= '0;
      end else begin
         A_VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (!key_s) begin
                  state <= DEB_PRESS;
                  cnt   <= '0;
               end
            end
            DEB_PRESS: begin
               if (key_s) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state    <= HELD;
                  A        <= sw_s;
                  A_VALID  <= 1'b1;
                  KEY_HELD <= 1'b1;
                  LOAD_CNT <= LOAD_CNT + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               if (key_s) begin
                  state <= DEB_REL;
                  cnt   <= '0;
               end
            end
            DEB_REL: begin
               // A bounce back low returns to HELD without a second capture.
               if (!key_s) begin
                  state <= HELD;
               end else if (cnt == CNT_LAST) begin
                  state    <= IDLE;
                  KEY_HELD <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_capture.sv
// Directed bench for operand_capture with a 4-cycle debounce period.
module tb_operand_capture;
   import operand_capture_pkg::*;

   localparam int DATA_W = 16;
   localparam int LCNT_W = 8;

   logic              CLOCK_50 = 1'b0;
   logic              RESET_N;
   logic              KEY_N;
   logic [DATA_W-1:0] SW;
   logic [DATA_W-1:0] A;
   logic              A_VALID;
   logic              KEY_HELD;
   logic [LCNT_W-1:0] LOAD_CNT;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int p0;

   operand_capture #(
      .DATA_W          (DATA_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
      .CNT_W           (3),
      .LCNT_W          (LCNT_W)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .KEY_N    (KEY_N),
      .SW       (SW),
      .A        (A),
      .A_VALID  (A_VALID),
      .KEY_HELD (KEY_HELD),
      .LOAD_CNT (LOAD_CNT)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Pulse counter sampled mid-cycle.
   always @(negedge CLOCK_50) if (A_VALID === 1'b1) pulses++;

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      tick(2);
      RESET_N = 1'b1;
      tick(2);
   endtask

   initial begin
      // 1: reset state, switches alone never move A
      RESET_N = 1'b0; KEY_N = 1'b1; SW = 16'hBEEF;
      tick(3);
      chk("rst_A", 32'(A), 32'h0);
      chk("rst_A_VALID", 32'(A_VALID), 32'h0);
      chk("rst_LOAD_CNT", 32'(LOAD_CNT), 32'h0);
      chk("rst_KEY_HELD", 32'(KEY_HELD), 32'h0);
      RESET_N = 1'b1;
      tick(2);
      SW = 16'hFFFF; tick(3); SW = 16'h1234; tick(3);
      chk("sw_toggle_A", 32'(A), 32'h0);
      chk("sw_toggle_AV", 32'(pulses), 32'd0);

      // 2: clean press, capture on edge 7
      SW = 16'h00A5; KEY_N = 1'b0;
      tick(6);
      chk("press_e6_AV", 32'(A_VALID), 32'h0);
      chk("press_e6_A", 32'(A), 32'h0);
      tick(1);
      chk("press_e7_A", 32'(A), 32'h00A5);
      chk("press_e7_AV", 32'(A_VALID), 32'h1);
      chk("press_e7_CNT", 32'(LOAD_CNT), 32'd1);
      chk("press_e7_HELD", 32'(KEY_HELD), 32'h1);
      tick(1);
      chk("press_e8_AV", 32'(A_VALID), 32'h0);
      SW = 16'h7777;
      tick(20);
      chk("hold_pulses", 32'(pulses), 32'd1);
      chk("hold_A", 32'(A), 32'h00A5);
      KEY_N = 1'b1;
      tick(6);
      chk("rel_e6_HELD", 32'(KEY_HELD), 32'h1);
      tick(1);
      chk("rel_e7_HELD", 32'(KEY_HELD), 32'h0);
      tick(3);

      // 3: short glitch rejected; a following press has normal latency
      KEY_N = 1'b0; tick(3); KEY_N = 1'b1;
      tick(10);
      chk("glitch_pulses", 32'(pulses), 32'd1);
      chk("glitch_A", 32'(A), 32'h00A5);
      chk("glitch_CNT", 32'(LOAD_CNT), 32'd1);
      chk("glitch_HELD", 32'(KEY_HELD), 32'h0);

      // 4: press, release bounce while held, clean release
      SW = 16'h1234; KEY_N = 1'b0;
      p0 = pulses;
      tick(6);
      chk("p4_e6_AV", 32'(A_VALID), 32'h0);
      tick(1);
      chk("p4_e7_AV", 32'(A_VALID), 32'h1);
      chk("p4_e7_A", 32'(A), 32'h1234);
      tick(5);
      KEY_N = 1'b1; tick(2); KEY_N = 1'b0;
      tick(12);
      chk("bounce_HELD", 32'(KEY_HELD), 32'h1);
      KEY_N = 1'b1;
      tick(6);
      chk("p4_rel_e6_HELD", 32'(KEY_HELD), 32'h1);
      tick(1);
      chk("p4_rel_e7_HELD", 32'(KEY_HELD), 32'h0);
      tick(5);
      chk("p4_one_pulse", 32'(pulses - p0), 32'd1);
      chk("p4_CNT", 32'(LOAD_CNT), 32'd2);

      // 5: reset during DEB_PRESS abandons the press
      SW = 16'hCAFE; KEY_N = 1'b0;
      tick(4);
      p0 = pulses;
      RESET_N = 1'b0; KEY_N = 1'b1;
      #2;
      chk("mid_rst_A", 32'(A), 32'h0);
      chk("mid_rst_CNT", 32'(LOAD_CNT), 32'd0);
      tick(1);
      RESET_N = 1'b1;
      tick(12);
      chk("post_rst_pulses", 32'(pulses - p0), 32'd0);
      chk("post_rst_A", 32'(A), 32'h0);
      SW = 16'h5A5A; KEY_N = 1'b0;
      tick(6);
      chk("p5_e6_AV", 32'(A_VALID), 32'h0);
      tick(1);
      chk("p5_e7_AV", 32'(A_VALID), 32'h1);
      chk("p5_e7_A", 32'(A), 32'h5A5A);
      chk("p5_e7_CNT", 32'(LOAD_CNT), 32'd1);
      KEY_N = 1'b1;
      tick(10);

      // 6: 257 presses wrap the 8-bit load counter
      do_reset();
      p0 = pulses;
      for (int i = 0; i <= 256; i++) begin
         SW = DATA_W'(i); KEY_N = 1'b0;
         tick(9);
         KEY_N = 1'b1;
         tick(9);
         if (i == 255) chk("wrap_CNT_256", 32'(LOAD_CNT), 32'd0);
         if (i == 100) chk("mid_A_100", 32'(A), 32'd100);
      end
      chk("final_CNT", 32'(LOAD_CNT), 32'd1);
      chk("final_A", 32'(A), 32'd256);
      chk("final_pulses", 32'(pulses - p0), 32'd257);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
